// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a five-stage pipeline.
// Purpose: selects operand forwarding sources for the ID stage, generates pipeline
// enable/flush controls for load-use stalls, taken branches and data-memory waits,
// and halts the pipeline if the data memory never answers.
// Ports:
//   clk, clr             - rising-edge clock, asynchronous active-low reset
//   ID_*                 - ID-stage source registers, read flags, branch_taken
//   EX_*, MEM_*, WB_*    - destination register / write-enable of later stages,
//                          EX load flag, MEM access and completion
//   fwd_rn/rm/rd         - 00 regfile, 01 EX, 10 MEM, 11 WB
//   *_enable, *_clr      - pipeline register controls (Mealy)
//   state                - 00 RUN, 01 MEM_WAIT, 10 HALT
//   mem_error            - sticky timeout flag
//   stall_count          - saturating count of cycles with the PC held
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  ID_rn,
  input  logic [3:0]  ID_rm,
  input  logic [3:0]  ID_rd,
  input  logic        ID_use_rn,
  input  logic        ID_use_rm,
  input  logic        ID_use_rd,
  input  logic        branch_taken,
  input  logic [3:0]  EX_rd,
  input  logic        EX_RF_enable,
  input  logic        EX_load_instr,
  input  logic [3:0]  MEM_rd,
  input  logic        MEM_RF_enable,
  input  logic        MEM_E,
  input  logic        mem_ready,
  input  logic [3:0]  WB_rd,
  input  logic        WB_RF_enable,
  output logic [1:0]  fwd_rn,
  output logic [1:0]  fwd_rm,
  output logic [1:0]  fwd_rd,
  output logic        PC_enable,
  output logic        IF_ID_enable,
  output logic        ID_EX_enable,
  output logic        EX_MEM_enable,
  output logic        IF_ID_clr,
  output logic        ID_EX_clr,
  output logic        MEM_WB_clr,
  output logic [1:0]  state,
  output logic        mem_error,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StHalt    = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_error_q, mem_error_d;
  logic [15:0] stall_count_q;

  logic ex_fwd_ok;
  logic load_use;
  logic freeze;
  logic halted;

  // A load in EX has no data yet, so it is never a forwarding source.
  assign ex_fwd_ok = EX_RF_enable & ~EX_load_instr;

  function automatic logic [1:0] fwd_sel(input logic       use_op,
                                         input logic [3:0] src,
                                         input logic [3:0] ex_rd,
                                         input logic       ex_ok,
                                         input logic [3:0] mem_rd,
                                         input logic       mem_ok,
                                         input logic [3:0] wb_rd,
                                         input logic       wb_ok);
    // r15 (PC) is never forwarded.
    if (!use_op || src == 4'd15)          return 2'b00;
    else if (ex_ok && ex_rd == src)       return 2'b01;
    else if (mem_ok && mem_rd == src)     return 2'b10;
    else if (wb_ok && wb_rd == src)       return 2'b11;
    else                                  return 2'b00;
  endfunction

  assign load_use = EX_load_instr && EX_RF_enable && (EX_rd != 4'd15) &&
                    ((ID_use_rn && ID_rn == EX_rd) ||
                     (ID_use_rm && ID_rm == EX_rd) ||
                     (ID_use_rd && ID_rd == EX_rd));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_error_d   = mem_error_q;
    freeze        = 1'b0;
    halted        = 1'b0;
    PC_enable     = 1'b1;
    IF_ID_enable  = 1'b1;
    ID_EX_enable  = 1'b1;
    EX_MEM_enable = 1'b1;
    IF_ID_clr     = 1'b0;
    ID_EX_clr     = 1'b0;
    MEM_WB_clr    = 1'b0;
    fwd_rn = fwd_sel(ID_use_rn, ID_rn, EX_rd, ex_fwd_ok, MEM_rd, MEM_RF_enable,
                     WB_rd, WB_RF_enable);
    fwd_rm = fwd_sel(ID_use_rm, ID_rm, EX_rd, ex_fwd_ok, MEM_rd, MEM_RF_enable,
                     WB_rd, WB_RF_enable);
    fwd_rd = fwd_sel(ID_use_rd, ID_rd, EX_rd, ex_fwd_ok, MEM_rd, MEM_RF_enable,
                     WB_rd, WB_RF_enable);

    case (state_q)
      StRun: begin
        if (MEM_E && !mem_ready) begin
          freeze     = 1'b1;
          state_d    = StMemWait;
          wait_cnt_d = 4'd0;
        end
      end
      StMemWait: begin
        // The completing cycle behaves as a normal RUN cycle.
        if (mem_ready) begin
          state_d = StRun;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == 4'd15) begin
            state_d     = StHalt;
            mem_error_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      StHalt:  halted = 1'b1;
      default: state_d = StRun;
    endcase

    if (halted) begin
      PC_enable     = 1'b0;
      IF_ID_enable  = 1'b0;
      ID_EX_enable  = 1'b0;
      EX_MEM_enable = 1'b0;
    end else if (freeze) begin
      PC_enable     = 1'b0;
      IF_ID_enable  = 1'b0;
      ID_EX_enable  = 1'b0;
      EX_MEM_enable = 1'b0;
      MEM_WB_clr    = 1'b1;
    end else if (load_use) begin
      // Branch is ignored here: ID re-presents it next cycle.
      PC_enable    = 1'b0;
      IF_ID_enable = 1'b0;
      ID_EX_clr    = 1'b1;
    end else if (branch_taken) begin
      IF_ID_clr = 1'b1;
    end

    // Reset overrides everything combinationally.
    if (!clr) begin
      PC_enable     = 1'b0;
      IF_ID_enable  = 1'b0;
      ID_EX_enable  = 1'b0;
      EX_MEM_enable = 1'b0;
      IF_ID_clr     = 1'b1;
      ID_EX_clr     = 1'b1;
      MEM_WB_clr    = 1'b1;
      fwd_rn        = 2'b00;
      fwd_rm        = 2'b00;
      fwd_rd        = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= StRun;
      wait_cnt_q    <= 4'd0;
      mem_error_q   <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      if (!PC_enable && stall_count_q != 16'hFFFF) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign state       = state_q;
  assign mem_error   = mem_error_q;
  assign stall_count = stall_count_q;

endmodule
